// File: rtl/riscv_multicycle_core_if.sv
// I-mem and D-mem valid/ready buses between the core (master) and the memory wrappers (slave).
interface riscv_multicycle_core_if;
    logic        mem_req_I;
    logic [31:0] mem_addr_I;
    logic [31:0] mem_rdata_I;
    logic        mem_ready_I;
    logic        mem_req_D;
    logic        mem_wen_D;
    logic [31:0] mem_addr_D;
    logic [31:0] mem_wdata_D;
    logic [31:0] mem_rdata_D;
    logic        mem_ready_D;

    modport master (
        output mem_req_I, mem_addr_I, mem_req_D, mem_wen_D, mem_addr_D, mem_wdata_D,
        input  mem_rdata_I, mem_ready_I, mem_rdata_D, mem_ready_D
    );

    modport slave (
        input  mem_req_I, mem_addr_I, mem_req_D, mem_wen_D, mem_addr_D, mem_wdata_D,
        output mem_rdata_I, mem_ready_I, mem_rdata_D, mem_ready_D
    );
endinterface

// File: rtl/riscv_multicycle_core.sv
// Multi-cycle RV32I/E core: ALU/branch/jump 2 cycles, lw/sw 3, plus one per I/D wait cycle; each req holds until its ready.
// Defining RISCV_MUL_EN adds mul as a 32-cycle shift-add in S_MUL; otherwise that encoding halts the core.
module riscv_multicycle_core #(
    parameter int          NUM_REGS  = 32,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter bit          BYTE_SWAP = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    riscv_multicycle_core_if.master bus,
    output logic                    halt,
    output logic [31:0]             instret
);
    localparam int AW = $clog2(NUM_REGS);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef enum logic [2:0] {S_IF, S_EX, S_MEM, S_HALT, S_MUL} state_t;
    state_t state, state_nxt;

    logic [31:0] pc, pc_nxt, pc_plus4, ir, daddr, dwdata;
    logic [31:0] rs1_val, rs2_val, rf_wd, alu_r;
    logic [31:0] imm_i, imm_s, imm_b, imm_j;
    logic        rf_we, retire, dlatch, r_ok, is_store;
    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [AW-1:0] rd_idx, rs1_idx, rs2_idx;
    logic [31:0] rf [NUM_REGS];

    function automatic logic [31:0] bswap(input logic [31:0] d);
        return BYTE_SWAP ? {d[7:0], d[15:8], d[23:16], d[31:24]} : d;
    endfunction

    assign opcode   = ir[6:0];
    assign funct3   = ir[14:12];
    assign funct7   = ir[31:25];
    assign rd_idx   = ir[7 +: AW];
    assign rs1_idx  = ir[15 +: AW];
    assign rs2_idx  = ir[20 +: AW];
    assign is_store = (opcode == OP_STORE);
    assign imm_i    = {{20{ir[31]}}, ir[31:20]};
    assign imm_s    = {{20{ir[31]}}, ir[31:25], ir[11:7]};
    assign imm_b    = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
    assign imm_j    = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
    assign pc_plus4 = pc + 32'd4;
    assign rs1_val  = rf[rs1_idx];
    assign rs2_val  = rf[rs2_idx];

    // x0 is a constant; only x1..x(N-1) hold state.
    assign rf[0] = '0;
    for (genvar g = 1; g < NUM_REGS; g++) begin : g_rf
        logic [31:0] q;
        always_ff @(posedge clk) begin
            if (!rst_n)                             q <= '0;
            else if (rf_we && rd_idx == AW'(g))     q <= rf_wd;
        end
        assign rf[g] = q;
    end

    always_comb begin
        r_ok  = 1'b1;
        alu_r = '0;
        case ({funct7, funct3})
            {7'b0000000, 3'b000}: alu_r = rs1_val + rs2_val;
            {7'b0100000, 3'b000}: alu_r = rs1_val - rs2_val;
            {7'b0000000, 3'b111}: alu_r = rs1_val & rs2_val;
            {7'b0000000, 3'b110}: alu_r = rs1_val | rs2_val;
            {7'b0000000, 3'b010}: alu_r = {31'b0, $signed(rs1_val) < $signed(rs2_val)};
            default:              r_ok  = 1'b0;
        endcase
    end

`ifdef RISCV_MUL_EN
    logic [31:0] mul_acc, mul_a, mul_b, mul_sum;
    logic [4:0]  mul_cnt;
    assign mul_sum = mul_acc + (mul_b[0] ? mul_a : 32'd0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mul_acc <= '0; mul_a <= '0; mul_b <= '0; mul_cnt <= '0;
        end else if (state == S_EX) begin
            mul_acc <= '0; mul_a <= rs1_val; mul_b <= rs2_val; mul_cnt <= '0;
        end else if (state == S_MUL) begin
            mul_acc <= mul_sum;
            mul_a   <= mul_a << 1;
            mul_b   <= mul_b >> 1;
            mul_cnt <= mul_cnt + 5'd1;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IF;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt       = state;
        pc_nxt          = pc;
        rf_we           = 1'b0;
        rf_wd           = '0;
        retire          = 1'b0;
        dlatch          = 1'b0;
        // Reset gates the fetch request so it is low for the whole reset window.
        bus.mem_req_I   = rst_n && (state == S_IF);
        bus.mem_addr_I  = pc;
        bus.mem_req_D   = (state == S_MEM);
        bus.mem_wen_D   = (state == S_MEM) && is_store;
        bus.mem_addr_D  = daddr;
        bus.mem_wdata_D = dwdata;
        halt            = (state == S_HALT);
        case (state)
            S_IF: if (bus.mem_ready_I) state_nxt = S_EX;
            S_EX: begin
                state_nxt = S_HALT;
                case (opcode)
                    OP_R: begin
                        if (r_ok) begin
                            rf_we = 1'b1; rf_wd = alu_r; pc_nxt = pc_plus4; retire = 1'b1; state_nxt = S_IF;
                        end
`ifdef RISCV_MUL_EN
                        else if (funct7 == 7'b0000001 && funct3 == 3'b000) state_nxt = S_MUL;
`endif
                    end
                    OP_IMM: if (funct3 == 3'b000) begin
                        rf_we = 1'b1; rf_wd = rs1_val + imm_i; pc_nxt = pc_plus4; retire = 1'b1; state_nxt = S_IF;
                    end
                    OP_LOAD, OP_STORE: if (funct3 == 3'b010) begin
                        dlatch = 1'b1; state_nxt = S_MEM;
                    end
                    OP_BRANCH: if (funct3[2:1] == 2'b00) begin
                        pc_nxt    = ((rs1_val == rs2_val) ^ funct3[0]) ? pc + imm_b : pc_plus4;
                        retire    = 1'b1;
                        state_nxt = S_IF;
                    end
                    OP_JAL: begin
                        rf_we = 1'b1; rf_wd = pc_plus4; pc_nxt = pc + imm_j; retire = 1'b1; state_nxt = S_IF;
                    end
                    OP_JALR: if (funct3 == 3'b000) begin
                        rf_we = 1'b1; rf_wd = pc_plus4; pc_nxt = (rs1_val + imm_i) & ~32'd1;
                        retire = 1'b1; state_nxt = S_IF;
                    end
                    default: ;
                endcase
            end
            S_MEM: if (bus.mem_ready_D) begin
                rf_we     = !is_store;
                rf_wd     = bswap(bus.mem_rdata_D);
                pc_nxt    = pc_plus4;
                retire    = 1'b1;
                state_nxt = S_IF;
            end
`ifdef RISCV_MUL_EN
            S_MUL: if (mul_cnt == 5'd31) begin
                rf_we = 1'b1; rf_wd = mul_sum; pc_nxt = pc_plus4; retire = 1'b1; state_nxt = S_IF;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc      <= RESET_PC;
            ir      <= '0;
            daddr   <= '0;
            dwdata  <= '0;
            instret <= '0;
        end else begin
            pc <= pc_nxt;
            if (state == S_IF && bus.mem_ready_I) ir <= bswap(bus.mem_rdata_I);
            if (dlatch) begin
                daddr  <= rs1_val + (is_store ? imm_s : imm_i);
                dwdata <= bswap(rs2_val);
            end
            if (retire) instret <= instret + 32'd1;
        end
    end
endmodule
